// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_sequencer
//  Brief    : Front-end for the multi-cycle divider: resolves special cases,
//             runs the divider once per operand pair and caches q/r.
//  Revision : 1.0  initial release
// ============================================================================
module div_sequencer #(
    parameter bit                      CACHE_EN     = 1'b1,
    parameter int                      DIV_OP_WIDTH = 2,
    parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV   = 'd0,
    parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU  = 'd1,
    parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_REM   = 'd2,
    parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU  = 'd3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DIV_OP_WIDTH-1:0] req_op,
    input  logic [31:0]             req_a,
    input  logic [31:0]             req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    input  logic                    flush,
    output logic                    div_valid,
    output logic [31:0]             div_divident,
    output logic [31:0]             div_divisor,
    output logic [DIV_OP_WIDTH-1:0] div_op,
    input  logic [31:0]             div_rslt,
    input  logic                    div_ready,
    input  logic                    div_dbz
);

    localparam logic [31:0] c_all_ones = 32'hFFFF_FFFF;
    localparam logic [31:0] c_int_min  = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPR  = 3'd3,
        S_RESP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIV_OP_WIDTH-1:0] r_op;
    logic [31:0]             r_a;
    logic [31:0]             r_b;
    logic                    r_s;
    logic [31:0]             r_q;
    logic [31:0]             r_rsp_data;
    logic                    r_c_vld;
    logic [31:0]             r_ca;
    logic [31:0]             r_cb;
    logic                    r_cs;
    logic [31:0]             r_cq;
    logic [31:0]             r_cr;

    logic        w_accept;
    logic        w_req_s;
    logic        w_req_rem;
    logic        w_dbz;
    logic        w_ovf;
    logic        w_hit;
    logic        w_fast;
    logic [31:0] w_fast_data;
    logic        w_op_rem;
    logic        w_drained;
    logic        w_unused_dbz;

    // Zero divisors are filtered here, so the divider's own error flag is moot
    assign w_unused_dbz = div_dbz;

    assign w_req_s   = (req_op == DIV_OP_DIV) || (req_op == DIV_OP_REM);
    assign w_req_rem = (req_op == DIV_OP_REM) || (req_op == DIV_OP_REMU);
    assign w_dbz     = (req_b == 32'd0);
    assign w_ovf     = w_req_s && (req_a == c_int_min) && (req_b == c_all_ones);
    assign w_hit     = CACHE_EN && r_c_vld && (req_a == r_ca) && (req_b == r_cb)
                       && (w_req_s == r_cs);
    assign w_fast    = w_dbz || w_ovf || w_hit;
    assign w_accept  = req_valid && req_ready;
    assign w_op_rem  = (r_op == DIV_OP_REM) || (r_op == DIV_OP_REMU);

    always_comb begin
        if (w_dbz)
            w_fast_data = w_req_rem ? req_a : c_all_ones;
        else if (w_ovf)
            w_fast_data = w_req_rem ? 32'd0 : c_int_min;
        else
            w_fast_data = w_req_rem ? r_cr : r_cq;
    end

    // Divider finished while the request is being abandoned
    assign w_drained = div_ready && ((r_state == S_DRAIN) || ((r_state == S_WAIT) && flush));

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        div_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush)
                    w_state_nxt = w_fast ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                div_valid   = 1'b1;
                w_state_nxt = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (div_ready)
                    w_state_nxt = flush ? S_IDLE : S_CAPR;
                else if (flush)
                    w_state_nxt = S_DRAIN;
            end
            S_CAPR:  w_state_nxt = flush ? S_IDLE : S_RESP;
            S_RESP: begin
                if (flush || rsp_ready)
                    w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (div_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op       <= DIV_OP_DIVU;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_s        <= 1'b0;
            r_q        <= 32'd0;
            r_rsp_data <= 32'd0;
            r_c_vld    <= 1'b0;
            r_ca       <= 32'd0;
            r_cb       <= 32'd0;
            r_cs       <= 1'b0;
            r_cq       <= 32'd0;
            r_cr       <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
                r_a  <= req_a;
                r_b  <= req_b;
                r_s  <= w_req_s;
                if (w_fast)
                    r_rsp_data <= w_fast_data;
            end
            if (div_ready && ((r_state == S_WAIT) || (r_state == S_DRAIN)))
                r_q <= div_rslt;
            if (w_drained) begin
                r_c_vld <= 1'b0;
            end else if ((r_state == S_CAPR) && !flush) begin
                r_c_vld    <= 1'b1;
                r_ca       <= r_a;
                r_cb       <= r_b;
                r_cs       <= r_s;
                r_cq       <= r_q;
                r_cr       <= div_rslt;
                r_rsp_data <= w_op_rem ? div_rslt : r_q;
            end
        end
    end

    // Remainder variant only while capturing r; quotient variant otherwise
    assign div_op       = (r_state == S_CAPR) ? (r_s ? DIV_OP_REM : DIV_OP_REMU)
                                              : (r_s ? DIV_OP_DIV : DIV_OP_DIVU);
    assign div_divident = r_a;
    assign div_divisor  = r_b;
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_data     = r_rsp_data;

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Initiator-side controller for the multi-cycle `divider` in the RV32IM execute stage. It accepts M-extension divide/remainder requests from the core and resolves divide-by-zero and signed overflow without launching the divider. Other requests are issued to the divider, and the sequencer waits for its `ready` pulse, then captures both quotient and remainder. A one-entry result cache returns the paired op (DIV→REM, DIVU→REMU, and the reverse) in one cycle.

## Interface
- `CACHE_EN`, default 1: enables the quotient/remainder pair cache; 0 means every non-special request launches the divider.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core request.
- `req_ready` out 1: request accepted on a cycle when `req_valid & req_ready`.
- `req_op` in `DIV_OP_WIDTH`: one of `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`.
- `req_a` in 32: dividend (rs1).
- `req_b` in 32: divisor (rs2).
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: core consumes the result.
- `rsp_data` out 32: result.
- `flush` in 1: pipeline kill; abandons the current request.
- `div_valid` out 1: to divider `valid`.
- `div_divident` out 32: to divider `divident`.
- `div_divisor` out 32: to divider `divisor`.
- `div_op` out `DIV_OP_WIDTH`: to divider `DIVop`.
- `div_rslt` in 32: from divider `divOrRemRslt`.
- `div_ready` in 1: from divider `ready`, a one-cycle pulse.
- `div_dbz` in 1: from divider `div_by_zero_err`; ignored, because zero divisors never reach the divider.

## Operation
States: IDLE, ISSUE, WAIT, CAPR, RESP, DRAIN.

- **Accept:** `req_ready` = 1 only in IDLE with `flush` = 0. On accept, latch op, a, b, and signed flag s = op ∈ {DIV, REM}.
- **Classification on accept** (first match wins):
  - **Divide-by-zero, b == 0:** DIV/DIVU give 0xFFFFFFFF; REM/REMU give a. Go to RESP.
  - **Signed overflow, s, a == 0x80000000, b == 0xFFFFFFFF:** DIV gives 0x80000000; REM gives 0. Go to RESP.
  - **Cache hit, `CACHE_EN` & cache valid & a == ca & b == cb & s == cs:** quotient ops give cq; remainder ops give cr. Go to RESP.
  - **Otherwise:** go to ISSUE.
- **Divider operands:** `div_divident`, `div_divisor` and `div_op` are driven from the latched registers and held stable from ISSUE until CAPR completes, because the divider re-reads operands for sign correction. `div_op` is the quotient variant (DIV if s, else DIVU) in ISSUE and WAIT, and the remainder variant (REM/REMU) in CAPR.
- **ISSUE:** `div_valid` = 1 for exactly one cycle, then go to WAIT. `div_valid` is 0 in every other state.
- **WAIT:** when `div_ready` = 1, capture q ← `div_rslt`, then go to CAPR.
- **CAPR:** capture r ← `div_rslt`. Load the cache with {a, b, s, q, r} and set it valid. Select the result by op, then go to RESP.
- **RESP:** `rsp_valid` = 1 and `rsp_data` is stable while `rsp_ready` = 0. On `rsp_ready`, go to IDLE.
- **Flush:**
  - In IDLE: no accept.
  - In RESP, ISSUE or CAPR: drop the request and go to IDLE. Any divider launched from ISSUE is handled by going to DRAIN instead of IDLE, so that the divider is drained.
  - In WAIT: go to DRAIN.
  - In DRAIN: wait for `div_ready`, then fill q only, mark the cache invalid, and go to IDLE.
  - `rsp_valid` is never asserted for a flushed request.
- **Cache:** cleared only by reset or a drained flush. It is overwritten on each completed divider run.

## Timing
- **Reset values:** `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `div_valid` = 0, `div_divident` = 0, `div_divisor` = 0, `div_op` = `DIV_OP_DIVU`, cache invalid, state IDLE.
- **Special case or cache hit:** `rsp_valid` is high in the cycle after acceptance, a 1-cycle latency.
- **Miss:** `div_valid` is high in the cycle after acceptance. `rsp_valid` is high 2 cycles after the cycle in which `div_ready` is high.
- **No fixed divider latency assumed:** the sequencer waits indefinitely for `div_ready`. With the current divider, `div_ready` arrives 34 cycles after the `div_valid` cycle.
- **Throughput:** one request is outstanding at a time. A new request can be accepted in the cycle after the RESP handshake.
- **Reset mid-operation:** all state returns to reset values immediately. The divider is reset by the same `resetn`, so no drain is needed.

## Test plan
- **DIVU miss, then REMU hit:** DIVU a=100, b=7 → one `div_valid` pulse, `rsp_data` = 14. Then REMU 100, 7 → `rsp_valid` next cycle, `rsp_data` = 2, no `div_valid`.
- **Signed pair:** DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. Then REM → 0xFFFFFFFF from cache. Then DIVU with the same operands → cache miss and a new divider run, giving 0x7FFFFFFC.
- **Special cases, each with 1-cycle latency and `div_valid` never high:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- **Flush in WAIT:** `flush` in WAIT, 10 cycles after `div_valid` → `req_ready` stays 0 until `div_ready`, then 1. The next REM with the same operands is a cache miss, and no `rsp_valid` appears for the flushed request.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid` and `rsp_data` stay stable and `req_ready` stays 0. Releasing `rsp_ready` completes the handshake and returns to IDLE the next cycle.
- **Reset mid-operation:** assert `resetn` = 0 in WAIT → all outputs return to their reset values asynchronously. After release, DIVU 9/3 → 3, and a REMU 9/3 issued before it misses the cache.
